// File: rtl/usb_audio_in_packetizer.sv
// Purpose : buffers 48 kHz 16-bit stereo ADC frames and emits one isochronous IN packet per USB SOF.
// Latency : first payload byte valid the cycle after the SOF edge; one byte per cycle while in_ready=1.
// Backpres: in_valid holds and in_data stays stable until in_ready; FIFO drops and counts frames when full.
// Ports   : clk/rstn (sync active-low), sample_valid/sample_l/sample_r (ADC side), sof (USB core),
//           in_data/in_valid/in_ready/in_last (IN endpoint byte stream), fifo_level, overflow_cnt.
// Config  : define AUDIO_IN_MONO_EN to send each frame as one 16-bit mono average (2 bytes per frame).
module usb_audio_in_packetizer #(
  parameter int FIFO_AW         = 7,
  parameter int MAX_PKT_SAMPLES = 49
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sample_valid,
  input  logic [15:0]        sample_l,
  input  logic [15:0]        sample_r,
  input  logic               sof,
  output logic [7:0]         in_data,
  output logic               in_valid,
  input  logic               in_ready,
  output logic               in_last,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [7:0]         overflow_cnt
);

`ifdef AUDIO_IN_MONO_EN
  localparam int BPS = 2;
`else
  localparam int BPS = 4;
`endif
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_MAXN = (FIFO_AW+1)'(MAX_PKT_SAMPLES);
  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ARMED, SEND} state_t;

  state_t             state, state_nxt;
  logic [31:0]        mem [DEPTH];          // {R, L}
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]         byte_idx, byte_idx_nxt;
  logic [FIFO_AW:0]   frames_left, frames_left_nxt;
  logic [FIFO_AW:0]   latch_n;
  logic [31:0]        head;
  logic               full, wr_en, accept, last_byte, pop;

  assign full      = (fifo_level == LVL_FULL);
  assign wr_en     = sample_valid & ~full;  // full judged on pre-pop level
  assign in_valid  = (state == SEND);
  assign accept    = in_valid & in_ready;
  assign last_byte = (byte_idx == 2'(BPS-1));
  assign pop       = accept & last_byte;
  assign latch_n   = (fifo_level > LVL_MAXN) ? LVL_MAXN : fifo_level;
  assign in_last   = in_valid & last_byte & (frames_left == LVL_ONE);
  assign head      = mem[rd_ptr];

`ifdef AUDIO_IN_MONO_EN
  // 17-bit sum of sign-extended channels; bits [16:1] are the arithmetic >>>1 result.
  logic [16:0] mono_sum;
  assign mono_sum = {head[15], head[15:0]} + {head[31], head[31:16]};
  always_comb begin
    in_data = 8'h00;
    if (in_valid) in_data = byte_idx[0] ? mono_sum[16:9] : mono_sum[8:1];
  end
`else
  always_comb begin
    in_data = 8'h00;
    if (in_valid) begin
      case (byte_idx)
        2'd0:    in_data = head[7:0];
        2'd1:    in_data = head[15:8];
        2'd2:    in_data = head[23:16];
        default: in_data = head[31:24];
      endcase
    end
  end
`endif

  always_comb begin
    state_nxt       = state;
    byte_idx_nxt    = byte_idx;
    frames_left_nxt = frames_left;
    case (state)
      IDLE, ARMED: begin
        if (sof) begin
          frames_left_nxt = latch_n;
          byte_idx_nxt    = 2'd0;
          state_nxt       = (latch_n != '0) ? SEND : ARMED;
        end
      end
      SEND: begin
        // sof is deliberately ignored here: the packet in flight is never truncated or re-latched.
        if (accept) begin
          if (last_byte) begin
            byte_idx_nxt    = 2'd0;
            frames_left_nxt = frames_left - LVL_ONE;
            if (frames_left == LVL_ONE) state_nxt = IDLE;
          end else begin
            byte_idx_nxt = byte_idx + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      frames_left  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      overflow_cnt <= 8'd0;
    end else begin
      state       <= state_nxt;
      byte_idx    <= byte_idx_nxt;
      frames_left <= frames_left_nxt;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      if (sample_valid && full && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {sample_r, sample_l};
  end

endmodule

// File: tb/tb_usb_audio_in_packetizer.sv
module tb_usb_audio_in_packetizer;
`ifdef AUDIO_IN_MONO_EN
  localparam int BPS = 2;
`else
  localparam int BPS = 4;
`endif
  localparam int MAXN  = 49;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rstn, sample_valid, sof, in_ready;
  logic [15:0] sample_l, sample_r;
  logic [7:0]  in_data;
  logic        in_valid, in_last;
  logic [7:0]  fifo_level;
  logic [7:0]  overflow_cnt;

  usb_audio_in_packetizer dut (
    .clk(clk), .rstn(rstn), .sample_valid(sample_valid), .sample_l(sample_l),
    .sample_r(sample_r), .sof(sof), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .fifo_level(fifo_level),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic l; } exp_t;

  exp_t        expq[$];     // scoreboard: expected payload bytes in order
  logic [31:0] mq[$];       // reference FIFO contents {R, L}
  int bytes_left = 0;       // bytes of the current packet still to be accepted
  int byte_pos   = 0;       // byte position within current frame
  int ovf        = 0;
  int errors     = 0;
  int checks     = 0;
  int rdy_mode   = 0;       // 0: always ready, 1: random, 2: stalled
  bit run        = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push_frame(input logic [31:0] f, input bit last_frame);
`ifdef AUDIO_IN_MONO_EN
    int m;
    m = (int'($signed(f[15:0])) + int'($signed(f[31:16]))) >>> 1;
    expq.push_back({8'(m), 1'b0});
    expq.push_back({8'(m >>> 8), last_frame});
`else
    expq.push_back({f[7:0],   1'b0});
    expq.push_back({f[15:8],  1'b0});
    expq.push_back({f[23:16], 1'b0});
    expq.push_back({f[31:24], last_frame});
`endif
  endfunction

  // Monitor: every accepted byte is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (run && in_valid && in_ready) begin
      if (expq.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_byte: got %0h expected none at %0t", in_data, $time);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("in_data", int'(in_data), int'(e.d));
        chk("in_last", int'(in_last), int'(e.l));
      end
    end
  end

  // Reference model: evaluates what the next clock edge does, after the monitor has sampled.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (run) begin
        int  pre, n;
        bit  acc, popf;
        pre  = mq.size();
        chk("in_valid",     int'(in_valid),     int'(bytes_left > 0));
        chk("fifo_level",   int'(fifo_level),   pre);
        chk("overflow_cnt", int'(overflow_cnt), ovf);
        if (!rstn) begin
          mq.delete(); expq.delete();
          bytes_left = 0; byte_pos = 0; ovf = 0;
        end else begin
          acc  = (bytes_left > 0) && in_ready;
          popf = 1'b0;
          if (sof && bytes_left == 0) begin
            n = (pre < MAXN) ? pre : MAXN;
            for (int i = 0; i < n; i++) push_frame(mq[i], i == n-1);
            bytes_left = n * BPS;
            byte_pos   = 0;
          end
          if (acc) begin
            bytes_left--;
            byte_pos++;
            if (byte_pos == BPS) begin byte_pos = 0; popf = 1'b1; end
          end
          if (sample_valid) begin
            if (pre == DEPTH) ovf = (ovf < 255) ? ovf + 1 : 255;
            else mq.push_back({sample_r, sample_l});
          end
          if (popf) void'(mq.pop_front());
        end
      end
    end
  end

  task automatic step(input bit sv, input bit sf, input logic [15:0] l, input logic [15:0] r);
    sample_valid = sv; sof = sf; sample_l = l; sample_r = r;
    case (rdy_mode)
      0:       in_ready = 1'b1;
      1:       in_ready = 1'($urandom_range(0, 1));
      default: in_ready = 1'b0;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (bytes_left > 0 && k < 3000) begin
      step(1'b0, 1'b0, 16'h0, 16'h0);
      k++;
    end
    chk("drain_timeout", bytes_left, 0);
    idle(1);
  endtask

  task automatic fill_rand(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    rstn = 1'b0; sample_valid = 1'b0; sof = 1'b0; in_ready = 1'b0;
    sample_l = 16'h0; sample_r = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_in_valid",   int'(in_valid), 0);
    chk("rst_in_last",    int'(in_last), 0);
    chk("rst_in_data",    int'(in_data), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_overflow",   int'(overflow_cnt), 0);
    rstn = 1'b1;
    run  = 1'b1;

    // Nominal 48-frame packet with ramp data
    rdy_mode = 0;
    for (int i = 0; i < 48; i++) step(1'b1, 1'b0, 16'h1234 + 16'(i), 16'hA5A0 + 16'(i));
    chk("t1_level_before", int'(fifo_level), 48);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    drain();
    chk("t1_level_after", int'(fifo_level), 0);

    // Empty FIFO: zero-length packet, then a 2-frame packet
    step(1'b0, 1'b1, 16'h0, 16'h0);
    idle(100);
    fill_rand(2);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    drain();

    // More than one packet's worth, with random backpressure
    rdy_mode = 1;
    fill_rand(60);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    drain();
    chk("t3_level_left", int'(fifo_level), 11);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    drain();

    // Overflow and saturation
    rdy_mode = 0;
    fill_rand(133);
    chk("t4_ovf5",  int'(overflow_cnt), 5);
    chk("t4_level", int'(fifo_level), 128);
    fill_rand(300);
    chk("t4_ovf_sat", int'(overflow_cnt), 255);
    for (int p = 0; p < 4; p++) begin
      step(1'b0, 1'b1, 16'h0, 16'h0);
      drain();
    end
    chk("t4_drained", int'(fifo_level), 0);

    // SOF during a stalled packet is ignored
    fill_rand(20);
    rdy_mode = 2;
    step(1'b0, 1'b1, 16'h0, 16'h0);
    idle(5);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    idle(3);
    rdy_mode = 0;
    drain();

    // Reset in the middle of a packet
    fill_rand(20);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    idle(10);
    rstn = 1'b0;
    step(1'b0, 1'b0, 16'h0, 16'h0);
    rstn = 1'b1;
    chk("t5_rst_valid", int'(in_valid), 0);
    chk("t5_rst_level", int'(fifo_level), 0);
    idle(5);

    // Mono/stereo corner values
    step(1'b1, 1'b0, 16'h7FFF, 16'h7FFF);
    step(1'b1, 1'b0, 16'h8000, 16'h0001);
    step(1'b1, 1'b0, 16'hFFFF, 16'h0000);
    step(1'b1, 1'b0, 16'h8000, 16'h8000);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    drain();

    // Random traffic: concurrent writes, SOFs and backpressure
    rdy_mode = 1;
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 249) == 0),
           16'($urandom), 16'($urandom));
    drain();

    idle(2);
    run = 1'b0;
    chk("leftover_expected", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
